// File: rtl/reg_file_scoreboard.sv
// Register file with per-register scoreboard: GPRs plus T/SP/IH/RA in one indexed space.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and busy state to the read ports.
module reg_file_scoreboard #(
   parameter int DATA_W  = 16,
   parameter int NUM_GPR = 8,
   parameter int ADDR_W  = 4
) (
   input  logic              clk_50MHz,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_a_addr,
   input  logic [ADDR_W-1:0] rd_b_addr,
   input  logic              rd_a_use,
   input  logic              rd_b_use,
   output logic [DATA_W-1:0] rd_a_data,
   output logic [DATA_W-1:0] rd_b_data,
   output logic              rd_a_busy,
   output logic              rd_b_busy,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              stall,
   output logic [DATA_W-1:0] t_data,
   output logic [DATA_W-1:0] sp_data,
   output logic [DATA_W-1:0] ih_data,
   output logic [DATA_W-1:0] ra_data
);

   localparam int NUM_REG = NUM_GPR + 4;
   localparam int IDX_T   = NUM_GPR;
   localparam int IDX_SP  = NUM_GPR + 1;
   localparam int IDX_IH  = NUM_GPR + 2;
   localparam int IDX_RA  = NUM_GPR + 3;

   // One-hot select; an out-of-range index matches no register and so yields all zeros.
   function automatic logic [NUM_REG-1:0] idx_onehot(input logic [ADDR_W-1:0] addr);
      logic [NUM_REG-1:0] hot;
      for (int i = 0; i < NUM_REG; i++) begin
         hot[i] = (addr == ADDR_W'(i));
      end
      return hot;
   endfunction

   logic [DATA_W-1:0]  regs_r [NUM_REG];
   logic [NUM_REG-1:0] busy_r;

   logic [NUM_REG-1:0] rd_a_hot_s;
   logic [NUM_REG-1:0] rd_b_hot_s;
   logic [NUM_REG-1:0] iss_hot_s;
   logic [NUM_REG-1:0] wr_hot_s;
   logic [DATA_W-1:0]  rd_a_data_s;
   logic [DATA_W-1:0]  rd_b_data_s;
   logic               rd_a_busy_s;
   logic               rd_b_busy_s;
   logic               iss_busy_s;
   logic               stall_s;
   logic               iss_ok_s;

   assign rd_a_hot_s = idx_onehot(rd_a_addr);
   assign rd_b_hot_s = idx_onehot(rd_b_addr);
   assign iss_hot_s  = idx_onehot(iss_addr);
   assign wr_hot_s   = idx_onehot(wr_addr) & {NUM_REG{wr_en}};

   // Read port A: stored value and busy bit, optionally overridden by same-cycle writeback.
   always_comb begin
      rd_a_data_s = {DATA_W{1'b0}};
      rd_a_busy_s = |(rd_a_hot_s & busy_r);
      for (int i = 0; i < NUM_REG; i++) begin
         rd_a_data_s = rd_a_data_s | (regs_r[i] & {DATA_W{rd_a_hot_s[i]}});
      end
`ifdef REGFILE_BYPASS_EN
      if (|(rd_a_hot_s & wr_hot_s)) begin
         rd_a_data_s = wr_data;
         rd_a_busy_s = iss_en & (iss_addr == rd_a_addr);
      end else begin
         rd_a_data_s = rd_a_data_s;
      end
`endif
   end

   // Read port B: same structure as port A.
   always_comb begin
      rd_b_data_s = {DATA_W{1'b0}};
      rd_b_busy_s = |(rd_b_hot_s & busy_r);
      for (int i = 0; i < NUM_REG; i++) begin
         rd_b_data_s = rd_b_data_s | (regs_r[i] & {DATA_W{rd_b_hot_s[i]}});
      end
`ifdef REGFILE_BYPASS_EN
      if (|(rd_b_hot_s & wr_hot_s)) begin
         rd_b_data_s = wr_data;
         rd_b_busy_s = iss_en & (iss_addr == rd_b_addr);
      end else begin
         rd_b_data_s = rd_b_data_s;
      end
`endif
   end

   // A second producer to a still-pending register must wait: a single busy bit cannot track two.
   assign iss_busy_s = iss_en & (|(iss_hot_s & busy_r & ~wr_hot_s));
   assign stall_s    = (rd_a_use & rd_a_busy_s) | (rd_b_use & rd_b_busy_s) | iss_busy_s;
   assign iss_ok_s   = iss_en & ~stall_s;

   // Storage and scoreboard update; an issue in the same cycle as a write leaves the register pending.
   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         for (int i = 0; i < NUM_REG; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
         busy_r <= {NUM_REG{1'b0}};
      end else begin
         for (int i = 0; i < NUM_REG; i++) begin
            if (wr_hot_s[i]) begin
               regs_r[i] <= wr_data;
            end
            if (iss_ok_s && iss_hot_s[i]) begin
               busy_r[i] <= 1'b1;
            end else if (wr_hot_s[i]) begin
               busy_r[i] <= 1'b0;
            end
         end
      end
   end

   assign rd_a_data = rd_a_data_s;
   assign rd_b_data = rd_b_data_s;
   assign rd_a_busy = rd_a_busy_s;
   assign rd_b_busy = rd_b_busy_s;
   assign stall     = stall_s;
   assign t_data    = regs_r[IDX_T];
   assign sp_data   = regs_r[IDX_SP];
   assign ih_data   = regs_r[IDX_IH];
   assign ra_data   = regs_r[IDX_RA];

   reg_file_scoreboard_chk #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_REG (NUM_REG)
   ) u_chk (
      .clk_50MHz (clk_50MHz),
      .rst       (rst),
      .rd_a_addr (rd_a_addr),
      .rd_b_addr (rd_b_addr),
      .rd_a_use  (rd_a_use),
      .rd_b_use  (rd_b_use),
      .rd_a_data (rd_a_data_s),
      .rd_b_data (rd_b_data_s),
      .rd_a_busy (rd_a_busy_s),
      .rd_b_busy (rd_b_busy_s),
      .iss_en    (iss_en),
      .stall     (stall_s)
   );

endmodule

// Invariant checks for reg_file_scoreboard; carries no functional logic.
module reg_file_scoreboard_chk #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 4,
   parameter int NUM_REG = 12
) (
   input logic              clk_50MHz,
   input logic              rst,
   input logic [ADDR_W-1:0] rd_a_addr,
   input logic [ADDR_W-1:0] rd_b_addr,
   input logic              rd_a_use,
   input logic              rd_b_use,
   input logic [DATA_W-1:0] rd_a_data,
   input logic [DATA_W-1:0] rd_b_data,
   input logic              rd_a_busy,
   input logic              rd_b_busy,
   input logic              iss_en,
   input logic              stall
);

   a_oor_a: assert property (@(posedge clk_50MHz) disable iff (rst)
      (32'(rd_a_addr) >= NUM_REG) |-> (rd_a_data == {DATA_W{1'b0}} && !rd_a_busy));

   a_oor_b: assert property (@(posedge clk_50MHz) disable iff (rst)
      (32'(rd_b_addr) >= NUM_REG) |-> (rd_b_data == {DATA_W{1'b0}} && !rd_b_busy));

   a_stall_cause: assert property (@(posedge clk_50MHz) disable iff (rst)
      stall |-> (rd_a_use || rd_b_use || iss_en));

endmodule
